ring_nic: RTL and testbench

RING_NIC -- requirements
Module: ring_nic

---
 rtl/ring_nic.sv | 70 +++++++
 tb/tb_ring_nic.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_nic.sv
// Ring network interface: one-entry input and output packet buffers between a
// processor register port and a polarity-gated router link.
module ring_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:1]  addr_nic,
    input  logic [0:63] dout_nic,
    output logic [0:63] din_nic,
    input  logic        nicEn,
    input  logic        nicWrEn,
    input  logic        net_polarity,
    output logic        net_so,
    input  logic        net_ro,
    output logic [0:63] net_do,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [0:63] net_di
);

    logic [0:63] icb;
    logic [0:63] ocb;
    logic        in_full;
    logic        out_full;
    logic        ocb_write;
    logic        icb_read;

    // Bit 0 of the packet selects which router phase may accept it.
    assign net_so    = out_full & net_ro & (ocb[0] == net_polarity);
    assign net_do    = ocb;
    assign net_ri    = ~in_full;
    assign ocb_write = nicEn & nicWrEn & (addr_nic == 2'b10) & ~out_full;
    assign icb_read  = nicEn & ~nicWrEn & (addr_nic == 2'b00) & in_full;

    always_comb begin
        din_nic = '0;
        case (addr_nic)
            2'b00:   din_nic = icb;
            2'b01:   din_nic = {63'b0, in_full};
            2'b11:   din_nic = {63'b0, out_full};
            default: din_nic = '0;
        endcase
    end

    // NOTE: the packet buffers are plain registers, so they are cleared with the
    // flags; otherwise net_do and din_nic would expose stale data under reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            icb      <= '0;
            ocb      <= '0;
            in_full  <= 1'b0;
            out_full <= 1'b0;
        end else begin
            // A send needs out_full=1 and a load needs out_full=0, so they never coincide.
            if (net_so) begin
                out_full <= 1'b0;
            end else if (ocb_write) begin
                ocb      <= dout_nic;
                out_full <= 1'b1;
            end

            if (net_si && net_ri) begin
                icb     <= net_di;
                in_full <= 1'b1;
            end else if (icb_read) begin
                in_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_nic.sv
// Directed bench for ring_nic: send path, polarity gating, discard rules,
// receive path with read-clear, and asynchronous reset with both buffers full.
module tb_ring_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:1]  addr_nic;
    logic [0:63] dout_nic;
    logic [0:63] din_nic;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_polarity;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;

    int n_checks = 0;
    int n_fail   = 0;

    ring_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr_nic     (addr_nic),
        .dout_nic     (dout_nic),
        .din_nic      (din_nic),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_polarity (net_polarity),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, well clear of the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_at(input logic [0:1] a);
        addr_nic = a;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        addr_nic = 2'b00;
        dout_nic = '0;
        nicEn = 1'b0;
        nicWrEn = 1'b0;
        net_polarity = 1'b0;
        net_ro = 1'b0;
        net_si = 1'b0;
        net_di = '0;
        #3;
        check("rst_net_so", {63'b0, net_so}, 64'd0);
        check("rst_net_ri", {63'b0, net_ri}, 64'd1);
        check("rst_net_do", net_do, 64'h0);
        check("rst_din_00", din_nic, 64'h0);

        tick();
        tick();
        reset = 1'b0;
        tick();

        // Plain send with matching polarity.
        net_ro = 1'b1;
        net_polarity = 1'b0;
        nicEn = 1'b1;
        nicWrEn = 1'b1;
        addr_nic = 2'b10;
        dout_nic = 64'h0000_0000_DEAD_BEEF;
        #1;
        check("send_pre_so", {63'b0, net_so}, 64'd0);
        tick();
        nicEn = 1'b0;
        read_at(2'b11);
        check("send_so", {63'b0, net_so}, 64'd1);
        check("send_do", net_do, 64'h0000_0000_DEAD_BEEF);
        check("send_full", din_nic, 64'd1);
        tick();
        check("send_done_so", {63'b0, net_so}, 64'd0);
        check("send_done_full", din_nic, 64'd0);

        // Polarity mismatch holds the packet; a second write is discarded.
        nicEn = 1'b1;
        addr_nic = 2'b10;
        dout_nic = 64'h8000_0000_0000_0001;
        tick();
        nicEn = 1'b0;
        read_at(2'b11);
        check("pol_hold_so", {63'b0, net_so}, 64'd0);
        check("pol_hold_full", din_nic, 64'd1);
        nicEn = 1'b1;
        addr_nic = 2'b10;
        dout_nic = 64'h0000_0000_0000_1234;
        tick();
        nicEn = 1'b0;
        check("discard_do", net_do, 64'h8000_0000_0000_0001);
        check("discard_so", {63'b0, net_so}, 64'd0);
        net_polarity = 1'b1;
        nicEn = 1'b1;
        #1;
        check("pol_send_so", {63'b0, net_so}, 64'd1);
        check("pol_send_do", net_do, 64'h8000_0000_0000_0001);
        tick();
        nicEn = 1'b0;
        read_at(2'b11);
        check("send_cycle_write_discard", net_do, 64'h8000_0000_0000_0001);
        check("pol_done_full", din_nic, 64'd0);
        check("pol_done_so", {63'b0, net_so}, 64'd0);

        // Receive, blocked second receive, read-clear.
        read_at(2'b01);
        check("rx_pre_ri", {63'b0, net_ri}, 64'd1);
        check("rx_pre_full", din_nic, 64'd0);
        net_si = 1'b1;
        net_di = 64'hA5A5_A5A5_A5A5_A5A5;
        tick();
        net_si = 1'b0;
        check("rx_full", din_nic, 64'd1);
        check("rx_ri", {63'b0, net_ri}, 64'd0);
        net_si = 1'b1;
        net_di = 64'h5A5A_5A5A_5A5A_5A5A;
        tick();
        net_si = 1'b0;
        read_at(2'b00);
        check("rx_blocked_icb", din_nic, 64'hA5A5_A5A5_A5A5_A5A5);
        read_at(2'b10);
        check("rd_addr10", din_nic, 64'h0);
        nicEn = 1'b1;
        nicWrEn = 1'b0;
        read_at(2'b00);
        check("rd_clear_data", din_nic, 64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        nicEn = 1'b0;
        check("rd_clear_ri", {63'b0, net_ri}, 64'd1);
        read_at(2'b01);
        check("rd_clear_full", din_nic, 64'd0);
        nicEn = 1'b1;
        read_at(2'b00);
        tick();
        nicEn = 1'b0;
        check("stale_icb", din_nic, 64'hA5A5_A5A5_A5A5_A5A5);
        check("stale_ri", {63'b0, net_ri}, 64'd1);

        // Writes to other addresses have no effect.
        nicEn = 1'b1;
        nicWrEn = 1'b1;
        dout_nic = 64'hFFFF_FFFF_FFFF_FFFF;
        addr_nic = 2'b00;
        tick();
        addr_nic = 2'b11;
        tick();
        nicEn = 1'b0;
        nicWrEn = 1'b0;
        check("wr00_icb", din_nic, 64'd0);
        read_at(2'b00);
        check("wr00_icb_data", din_nic, 64'hA5A5_A5A5_A5A5_A5A5);
        check("wr_other_do", net_do, 64'h8000_0000_0000_0001);

        // Fill both buffers, then reset asynchronously between edges.
        net_ro = 1'b0;
        nicEn = 1'b1;
        nicWrEn = 1'b1;
        addr_nic = 2'b10;
        dout_nic = 64'h0000_0000_0000_CAFE;
        net_si = 1'b1;
        net_di = 64'h0000_0000_0000_0077;
        tick();
        nicEn = 1'b0;
        nicWrEn = 1'b0;
        net_si = 1'b0;
        read_at(2'b01);
        check("fill_in_full", din_nic, 64'd1);
        read_at(2'b11);
        check("fill_out_full", din_nic, 64'd1);
        reset = 1'b1;
        net_ro = 1'b1;
        net_polarity = 1'b0;
        #1;
        check("arst_ri", {63'b0, net_ri}, 64'd1);
        check("arst_so", {63'b0, net_so}, 64'd0);
        check("arst_do", net_do, 64'h0);
        check("arst_out_full", din_nic, 64'd0);
        read_at(2'b01);
        check("arst_in_full", din_nic, 64'd0);
        read_at(2'b00);
        check("arst_icb", din_nic, 64'h0);

        // Normal operation resumes after release.
        @(negedge clk);
        reset = 1'b0;
        tick();
        nicEn = 1'b1;
        nicWrEn = 1'b1;
        addr_nic = 2'b10;
        dout_nic = 64'h0000_0000_0000_0042;
        tick();
        nicEn = 1'b0;
        nicWrEn = 1'b0;
        check("resume_so", {63'b0, net_so}, 64'd1);
        check("resume_do", net_do, 64'h0000_0000_0000_0042);
        tick();
        check("resume_done_so", {63'b0, net_so}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
